// File: rtl/note_freq_seq.sv
// Note-to-divisor sequencer: latches key presses, sustains them for a tick-counted hold,
// and decodes left/right half-period divisors with an optional harmony interval.
module note_freq_seq #(
   parameter int unsigned DIV_W      = 22,
   parameter int unsigned INTERVAL   = 2,
   parameter int unsigned HOLD_TICKS = 50,
   parameter int unsigned TICK_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [3:0]       key_in,
   input  logic             mode,
   input  logic             shift_down,
   input  logic             harmony_en,
   output logic [DIV_W-1:0] note_div_left,
   output logic [DIV_W-1:0] note_div_right,
   output logic [3:0]       letter,
   output logic             active
);

   typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

   localparam logic [TICK_W-1:0] HoldLoad  = TICK_W'(HOLD_TICKS);
   localparam logic [4:0]        IntervalW = 5'(INTERVAL);

   state_e            r_state;
   logic [3:0]        r_note;
   logic              r_harm;
   logic [TICK_W-1:0] r_cnt;

   logic              w_valid;
   logic [3:0]        w_idx;
   logic [4:0]        w_right_idx;

   // Half-period divisors for indices 1..16; everything else is the silent divisor 1.
   function automatic logic [17:0] div_lut(input logic [4:0] idx);
      case (idx)
         5'd1:    div_lut = 18'd191571;
         5'd2:    div_lut = 18'd170648;
         5'd3:    div_lut = 18'd151515;
         5'd4:    div_lut = 18'd143266;
         5'd5:    div_lut = 18'd127551;
         5'd6:    div_lut = 18'd113636;
         5'd7:    div_lut = 18'd101215;
         5'd8:    div_lut = 18'd95420;
         5'd9:    div_lut = 18'd85034;
         5'd10:   div_lut = 18'd75758;
         5'd11:   div_lut = 18'd71633;
         5'd12:   div_lut = 18'd63776;
         5'd13:   div_lut = 18'd56818;
         5'd14:   div_lut = 18'd50607;
         5'd15:   div_lut = 18'd47801;
         5'd16:   div_lut = 18'd42553;
         default: div_lut = 18'd1;
      endcase
   endfunction

   always_comb begin
      w_valid = (key_in >= 4'd1) && (key_in <= 4'd7);
      w_idx   = (mode ^ shift_down) ? key_in + 4'd7 : key_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_note  <= 4'd0;
         r_harm  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_valid) begin
                  r_state <= StPlay;
                  r_note  <= w_idx;
                  r_harm  <= harmony_en;
               end
            end
            StPlay: begin
               if (w_valid) begin
                  r_note <= w_idx;
                  r_harm <= harmony_en;
               end else if (HOLD_TICKS == 0) begin
                  r_state <= StIdle;
                  r_note  <= 4'd0;
                  r_harm  <= 1'b0;
               end else begin
                  // Loading the counter swallows any tick arriving with the release.
                  r_state <= StHold;
                  r_cnt   <= HoldLoad;
               end
            end
            StHold: begin
               if (w_valid) begin
                  r_state <= StPlay;
                  r_note  <= w_idx;
                  r_harm  <= harmony_en;
               end else if (tick) begin
                  if (r_cnt > TICK_W'(1)) begin
                     r_cnt <= r_cnt - 1'b1;
                  end else begin
                     r_state <= StIdle;
                     r_cnt   <= '0;
                     r_note  <= 4'd0;
                     r_harm  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= StIdle;
               r_note  <= 4'd0;
               r_harm  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Right index kept at 5 bits so note + interval beyond 16 falls into the silent default.
   always_comb begin
      w_right_idx    = r_harm ? ({1'b0, r_note} + IntervalW) : {1'b0, r_note};
      note_div_left  = DIV_W'(div_lut({1'b0, r_note}));
      note_div_right = DIV_W'(div_lut(w_right_idx));
      letter         = r_note;
      active         = (r_state != StIdle);
   end

endmodule

// File: tb/tb_note_freq_seq.sv
// Directed bench for note_freq_seq: two instances share stimulus, one with a 3-tick hold and
// interval 2, the other with interval 3 and no hold.
module tb_note_freq_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic [3:0]  key_in;
   logic        mode;
   logic        shift_down;
   logic        harmony_en;

   logic [21:0] a_left, a_right, b_left, b_right;
   logic [3:0]  a_letter, b_letter;
   logic        a_active, b_active;

   int total = 0;
   int bad   = 0;

   logic [48:0] a_obs, b_obs;
   assign a_obs = {a_left, a_right, a_letter, a_active};
   assign b_obs = {b_left, b_right, b_letter, b_active};

   always #5 clk = ~clk;

   note_freq_seq #(
      .DIV_W(22), .INTERVAL(2), .HOLD_TICKS(3), .TICK_W(8)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(key_in), .mode(mode),
      .shift_down(shift_down), .harmony_en(harmony_en),
      .note_div_left(a_left), .note_div_right(a_right), .letter(a_letter), .active(a_active)
   );

   note_freq_seq #(
      .DIV_W(22), .INTERVAL(3), .HOLD_TICKS(0), .TICK_W(8)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(key_in), .mode(mode),
      .shift_down(shift_down), .harmony_en(harmony_en),
      .note_div_left(b_left), .note_div_right(b_right), .letter(b_letter), .active(b_active)
   );

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tick = 1'b0; key_in = 4'd0; mode = 1'b0;
      shift_down = 1'b0; harmony_en = 1'b0;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick = 1'b0; key_in = 4'd0; mode = 1'b0;
      shift_down = 1'b0; harmony_en = 1'b0;
      #2;
      total++;
      if (a_obs !== {22'd1, 22'd1, 4'd0, 1'b0}) begin
         bad++; $display("FAIL reset_a: got %h want %h", a_obs, {22'd1, 22'd1, 4'd0, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if (a_obs !== {22'd1, 22'd1, 4'd0, 1'b0} || b_obs !== {22'd1, 22'd1, 4'd0, 1'b0}) begin
            bad++; $display("FAIL idle_%0d: got a=%h b=%h want both %h", i, a_obs, b_obs,
                            {22'd1, 22'd1, 4'd0, 1'b0});
         end
      end
   endtask

   task automatic test_octave();
      do_reset();
      key_in = 4'd3;
      #1;
      total++;
      if (a_obs !== {22'd1, 22'd1, 4'd0, 1'b0}) begin
         bad++; $display("FAIL no_comb_path: got %h want %h", a_obs, {22'd1, 22'd1, 4'd0, 1'b0});
      end
      step();
      total++;
      if (a_obs !== {22'd151515, 22'd151515, 4'd3, 1'b1}) begin
         bad++; $display("FAIL low_oct: got %h want %h", a_obs, {22'd151515, 22'd151515, 4'd3, 1'b1});
      end
      mode = 1'b1;
      step();
      total++;
      if (a_obs !== {22'd75758, 22'd75758, 4'd10, 1'b1}) begin
         bad++; $display("FAIL up_oct: got %h want %h", a_obs, {22'd75758, 22'd75758, 4'd10, 1'b1});
      end
      shift_down = 1'b1;
      step();
      total++;
      if (a_obs !== {22'd151515, 22'd151515, 4'd3, 1'b1}) begin
         bad++; $display("FAIL shift_inv: got %h want %h", a_obs, {22'd151515, 22'd151515, 4'd3, 1'b1});
      end
   endtask

   task automatic test_harmony();
      do_reset();
      harmony_en = 1'b1; mode = 1'b1; key_in = 4'd5;
      step();
      total++;
      if (a_obs !== {22'd63776, 22'd50607, 4'd12, 1'b1}) begin
         bad++; $display("FAIL harm_12_i2: got %h want %h", a_obs, {22'd63776, 22'd50607, 4'd12, 1'b1});
      end
      total++;
      if (b_obs !== {22'd63776, 22'd47801, 4'd12, 1'b1}) begin
         bad++; $display("FAIL harm_12_i3: got %h want %h", b_obs, {22'd63776, 22'd47801, 4'd12, 1'b1});
      end
      key_in = 4'd7;
      step();
      total++;
      if (a_obs !== {22'd50607, 22'd42553, 4'd14, 1'b1}) begin
         bad++; $display("FAIL harm_16: got %h want %h", a_obs, {22'd50607, 22'd42553, 4'd14, 1'b1});
      end
      total++;
      if (b_obs !== {22'd50607, 22'd1, 4'd14, 1'b1}) begin
         bad++; $display("FAIL harm_ovf: got %h want %h", b_obs, {22'd50607, 22'd1, 4'd14, 1'b1});
      end
   endtask

   task automatic test_hold();
      do_reset();
      key_in = 4'd1;
      step();
      // Release with a coincident tick that must not be counted.
      key_in = 4'd0; tick = 1'b1;
      step();
      total++;
      if (a_obs !== {22'd191571, 22'd191571, 4'd1, 1'b1}) begin
         bad++; $display("FAIL hold_enter: got %h want %h", a_obs, {22'd191571, 22'd191571, 4'd1, 1'b1});
      end
      total++;
      if (b_obs !== {22'd1, 22'd1, 4'd0, 1'b0}) begin
         bad++; $display("FAIL zero_hold: got %h want %h", b_obs, {22'd1, 22'd1, 4'd0, 1'b0});
      end
      tick = 1'b0; harmony_en = 1'b1;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      tick = 1'b1;
      step();
      total++;
      if (a_obs !== {22'd191571, 22'd191571, 4'd1, 1'b1}) begin
         bad++; $display("FAIL hold_tick2: got %h want %h", a_obs, {22'd191571, 22'd191571, 4'd1, 1'b1});
      end
      step();
      tick = 1'b0;
      total++;
      if (a_obs !== {22'd1, 22'd1, 4'd0, 1'b0}) begin
         bad++; $display("FAIL hold_tick3: got %h want %h", a_obs, {22'd1, 22'd1, 4'd0, 1'b0});
      end
      harmony_en = 1'b0;
   endtask

   task automatic test_repress();
      do_reset();
      key_in = 4'd1;
      step();
      key_in = 4'd0;
      step();
      tick = 1'b1;
      step();
      // Press plus tick together: the press wins.
      key_in = 4'd2;
      step();
      total++;
      if (a_obs !== {22'd170648, 22'd170648, 4'd2, 1'b1}) begin
         bad++; $display("FAIL repress: got %h want %h", a_obs, {22'd170648, 22'd170648, 4'd2, 1'b1});
      end
      key_in = 4'd0; tick = 1'b0;
      step();
      harmony_en = 1'b1; tick = 1'b1;
      step();
      step();
      tick = 1'b0;
      total++;
      if (a_obs !== {22'd170648, 22'd170648, 4'd2, 1'b1}) begin
         bad++; $display("FAIL reload_frz: got %h want %h", a_obs, {22'd170648, 22'd170648, 4'd2, 1'b1});
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (a_obs !== {22'd1, 22'd1, 4'd0, 1'b0}) begin
         bad++; $display("FAIL async_rst: got %h want %h", a_obs, {22'd1, 22'd1, 4'd0, 1'b0});
      end
      harmony_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_octave();
      test_harmony();
      test_hold();
      test_repress();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
